pipelined_cla_adder: RTL and testbench
======================================

Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined successor to the team's 4-bit carry-lookahead adder.
- Splits a WIDTH-bit add/subtract into WIDTH/GROUP carry-lookahead groups, one pipeline stage per group.
- The group carry is registered between stages and operands are skewed.
- Valid/ready streaming handshake, subtract mode and signed-overflow flag; sits on datapath streams where full-width single-cycle carry would limit fmax.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of GROUP (elaboration error otherwise).
- GROUP, 4, bits per CLA group (legal 1..8); the pipeline has NSTAGE = WIDTH/GROUP stages.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands on A/B/cin/sub are valid.
- in_ready  output  1  block accepts operands this cycle.
- A  input  WIDTH  operand A (unsigned or two's complement).
- B  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  1: Y = A - B (A + ~B + 1, cin ignored); 0: Y = A + B + cin.
- out_valid  output  1  Y/cout/ovf are valid.
- out_ready  input  1  downstream accepts result.
- Y  output  WIDTH  sum/difference, modulo 2^WIDTH.
- cout  output  1  carry out of MSB (for sub: 1 means no borrow, A >= B unsigned).
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, Y, cout, ovf and out_valid are 0. in_ready is 1 after reset since the pipeline is empty.
- Advance enable: en = !out_valid || out_ready. All stages shift together when en=1 and hold when en=0 (global stall, no bubble collapsing).
- in_ready = en. This is a combinational path from out_ready and is documented for integrators.
- A transfer occurs when in_valid && in_ready. When en=1 and in_valid=0, a bubble (valid=0) enters stage 0.
- Stage k (0..NSTAGE-1):
  - Computes the CLA over bits [k*GROUP +: GROUP] using per-bit generate g=a&b'' and propagate p=a^b''. b'' = sub ? ~B : B.
  - Group carry-out = G | P&c_in, with the lookahead form inside the group (no ripple).
  - Stage 0 carry-in = sub ? 1 : cin.
  - Stage k registers its group sum bits, its carry-out, and the not-yet-consumed higher operand slices.
  - Lower result slices already computed are carried forward.
- Latency: exactly NSTAGE cycles from the accepting edge to out_valid=1 with the full result, assuming no stalls. Throughput is 1 result/cycle.
- Output registers hold value while out_valid && !out_ready. Y/cout/ovf are stable until the handshake completes.
- When a bubble reaches the output, out_valid=0. Y/cout/ovf may hold stale values but must not be X after reset.
- Result ordering is strictly FIFO; no result is dropped or duplicated under any stall pattern.
- Sub mode: cin is ignored entirely. sub and cin travel with their transaction, so a mode change between back-to-back transfers is legal.
- ovf uses the carry into the MSB within the last group. For GROUP=1 that is the previous stage carry.
- Reset mid-operation: all in-flight transactions are discarded and out_valid drops asynchronously; no result emerges for pre-reset inputs.
- NSTAGE=1 (WIDTH=GROUP) is legal: a registered single-cycle adder with latency 1.
- Results must equal the behavioural reference {cout,Y} = A + b'' + cin_eff for all inputs (bit-exact). The bench compares against an inferred "+" model, as with the 4-bit CLA.

Test Plan:
- WIDTH=4, GROUP=4, out_ready=1: exhaustive A,B in 0..15, cin in 0..1, sub=0. Each {cout,Y} equals A+B+cin one cycle after accept; all 512 vectors match.
- WIDTH=16, GROUP=4: A=0xFFFF, B=0x0001, cin=0 → Y=0x0000, cout=1, ovf=0, out_valid exactly 4 cycles after accept. A=0x7FFF, B=0x0001 → Y=0x8000, cout=0, ovf=1.
- Subtract: A=0x0003, B=0x0005, sub=1, cin=1 → Y=0xFFFE, cout=0, ovf=0 (cin ignored). A=0x8000, B=0x0001, sub=1 → Y=0x7FFF, cout=1, ovf=1.
- Back-to-back stream of 100 random transfers with out_ready toggled randomly (about 50%) and in_valid random. Results arrive in order, each matches the model, count in equals count out. Y is held stable while stalled.
- Assert rst_n low for 1 cycle while 3 transactions are in flight. out_valid=0 immediately, Y=0, no stale results afterwards, and the next accepted transaction completes normally after 4 cycles.
- Parameter sweep (WIDTH,GROUP) in {(8,1),(8,8),(32,4),(24,8)}: 1000 random vectors each with random sub/cin. Latency equals WIDTH/GROUP and all results match the inferred model.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with a valid/ready stream interface.
// The WIDTH-bit operation is split into WIDTH/GROUP lookahead groups. Each
// pipeline stage resolves one group. The group carry is registered between
// stages, and the not-yet-consumed operand slices are skewed forward.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTAGE = WIDTH / GROUP;

  if (GROUP < 1 || GROUP > 8 || (WIDTH % GROUP) != 0) begin : g_param_check
    $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP, GROUP in 1..8");
  end

  // Two-level lookahead carries for one group: every carry is a flat
  // sum of products of g/p and the group carry-in, so nothing ripples.
  function automatic logic [GROUP:0] cla_carries(input logic [GROUP-1:0] g,
                                                 input logic [GROUP-1:0] p,
                                                 input logic             c0);
    logic [GROUP:0] c;
    logic           term;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < GROUP; i++) begin
      term = c0;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  logic              en;
  logic [NSTAGE-1:0] vld_p;
  logic [WIDTH-1:0]  b_eff;
  logic              c0;

  // Global stall: every stage moves only when the output slot can be freed.
  // in_ready is therefore combinational from out_ready.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Subtract is A + ~B + 1. cin only matters for add.
  assign b_eff = sub ? ~B : B;
  assign c0    = sub | cin;

  // Valid bits shift with the data; a bubble enters when in_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  vld_p <= '0;
    else if (en) vld_p <= NSTAGE'({vld_p, in_valid});
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : stage
    localparam int LO   = k * GROUP;
    localparam int HI_W = WIDTH - LO - GROUP;

    logic [GROUP-1:0]    a_s;
    logic [GROUP-1:0]    b_s;
    logic [GROUP-1:0]    s;
    logic [GROUP:0]      c;
    logic                c_i;
    logic                vld_i;
    logic [LO+GROUP-1:0] y_n;
    logic [LO+GROUP-1:0] y_p;
    logic                c_p;

    if (k == 0) begin : g_src
      assign a_s   = A[GROUP-1:0];
      assign b_s   = b_eff[GROUP-1:0];
      assign c_i   = c0;
      assign vld_i = in_valid;
      assign y_n   = s;
    end else begin : g_src
      assign a_s   = stage[k-1].g_ops.a_p[GROUP-1:0];
      assign b_s   = stage[k-1].g_ops.b_p[GROUP-1:0];
      assign c_i   = stage[k-1].c_p;
      assign vld_i = vld_p[k-1];
      assign y_n   = {s, stage[k-1].y_p};
    end

    assign c = cla_carries(a_s & b_s, a_s ^ b_s, c_i);
    assign s = a_s ^ b_s ^ c[GROUP-1:0];

    if (k == NSTAGE - 1) begin : g_out
      logic ovf_p;
      // Output stage: full result, carry out and overflow (carry into MSB vs out of MSB).
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          y_p   <= '0;
          c_p   <= 1'b0;
          ovf_p <= 1'b0;
        end else if (en && vld_i) begin
          y_p   <= y_n;
          c_p   <= c[GROUP];
          ovf_p <= c[GROUP] ^ c[GROUP-1];
        end
      end
    end else begin : g_mid
      // Intermediate stage: partial sum and group carry, loaded only for live data.
      always_ff @(posedge clk) begin
        if (en && vld_i) begin
          y_p <= y_n;
          c_p <= c[GROUP];
        end
      end
    end

    if (k < NSTAGE - 1) begin : g_ops
      logic [HI_W-1:0] a_p;
      logic [HI_W-1:0] b_p;
      logic [HI_W-1:0] a_hi;
      logic [HI_W-1:0] b_hi;
      if (k == 0) begin : g_hi
        assign a_hi = A[WIDTH-1:GROUP];
        assign b_hi = b_eff[WIDTH-1:GROUP];
      end else begin : g_hi
        assign a_hi = stage[k-1].g_ops.a_p[HI_W+GROUP-1:GROUP];
        assign b_hi = stage[k-1].g_ops.b_p[HI_W+GROUP-1:GROUP];
      end
      // Skew the higher operand slices forward for the later groups.
      always_ff @(posedge clk) begin
        if (en && vld_i) begin
          a_p <= a_hi;
          b_p <= b_hi;
        end
      end
    end
  end

  // stage boundary: output registers
  assign out_valid = vld_p[NSTAGE-1];
  assign Y         = stage[NSTAGE-1].y_p;
  assign cout      = stage[NSTAGE-1].c_p;
  assign ovf       = stage[NSTAGE-1].g_out.ovf_p;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Testbench for pipelined_cla_adder: exhaustive 4-bit, directed 16-bit corner
// cases, a randomly stalled stream, mid-flight reset and a parameter sweep.
module tb_pipelined_cla_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst_m;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer add; result packed as {ovf, cout, Y} with Y in bits [w-1:0].
  function automatic logic [63:0] ref_add(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub);
    logic [63:0] mask, aa, bb, sum;
    logic        co, ov;
    mask = (64'd1 << w) - 64'd1;
    aa   = a & mask;
    bb   = sub ? (~b & mask) : (b & mask);
    sum  = aa + bb + {63'd0, (sub ? 1'b1 : cin)};
    co   = sum[w];
    ov   = (aa[w-1] == bb[w-1]) && (sum[w-1] != aa[w-1]);
    return (sum & mask) | ({63'd0, co} << w) | ({63'd0, ov} << (w + 1));
  endfunction

  // ---------------- main 16/4 instance ----------------
  logic [15:0] m_a, m_b, m_y;
  logic        m_cin, m_sub, m_iv, m_ir, m_ov, m_or, m_cout, m_ovf;

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut (
    .clk(clk), .rst_n(rst_m), .in_valid(m_iv), .in_ready(m_ir), .A(m_a), .B(m_b),
    .cin(m_cin), .sub(m_sub), .out_valid(m_ov), .out_ready(m_or), .Y(m_y),
    .cout(m_cout), .ovf(m_ovf));

  // ---------------- exhaustive 4/4 instance ----------------
  logic [3:0] e_a, e_b, e_y;
  logic       e_cin, e_iv, e_ir, e_ov, e_co, e_of;

  pipelined_cla_adder #(.WIDTH(4), .GROUP(4)) dut_e (
    .clk(clk), .rst_n(rst_n), .in_valid(e_iv), .in_ready(e_ir), .A(e_a), .B(e_b),
    .cin(e_cin), .sub(1'b0), .out_valid(e_ov), .out_ready(1'b1), .Y(e_y),
    .cout(e_co), .ovf(e_of));

  // ---------------- parameter sweep ----------------
  localparam int SW_W [4] = '{8, 8, 32, 24};
  localparam int SW_G [4] = '{1, 8, 4, 8};

  for (genvar i = 0; i < 4; i++) begin : sw
    localparam int W  = SW_W[i];
    localparam int NS = SW_W[i] / SW_G[i];
    logic [W-1:0] a, b, y;
    logic         cin_s, sub_s, iv, ir, ov, co, of;
    logic         done;

    pipelined_cla_adder #(.WIDTH(W), .GROUP(SW_G[i])) dut_s (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .A(a), .B(b),
      .cin(cin_s), .sub(sub_s), .out_valid(ov), .out_ready(1'b1), .Y(y),
      .cout(co), .ovf(of));

    initial begin
      logic [63:0] exp_arr [1000];
      int          v;
      done = 1'b0; iv = 1'b0; a = '0; b = '0; cin_s = 1'b0; sub_s = 1'b0;
      @(posedge rst_n);
      for (int n = 0; n < 1000 + NS; n++) begin
        @(negedge clk);
        if (n < 1000) begin
          iv = 1'b1; a = W'($urandom); b = W'($urandom);
          cin_s = 1'($urandom); sub_s = 1'($urandom);
          exp_arr[n] = ref_add(W, 64'(a), 64'(b), cin_s, sub_s);
        end else begin
          iv = 1'b0;
        end
        @(posedge clk); #1;
        if (n == 0) check($sformatf("sw%0d_ready", i), 64'(ir), 64'd1);
        v = n - NS + 1;
        check($sformatf("sw%0d_valid", i), 64'(ov), 64'((v >= 0) && (v < 1000)));
        if (v >= 0 && v < 1000)
          check($sformatf("sw%0d_result", i), 64'({of, co, y}), exp_arr[v]);
      end
      done = 1'b1;
    end
  end

  // One isolated transfer on the main instance; returns result and edges to out_valid.
  task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                         output logic [63:0] res, output int lat);
    @(negedge clk);
    m_a = a; m_b = b; m_cin = c; m_sub = s; m_iv = 1'b1; m_or = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      m_iv = 1'b0;
    end while (!m_ov && lat < 20);
    res = 64'({m_ovf, m_cout, m_y});
  endtask

  initial begin
    logic [63:0] r, prev, exp;
    logic [63:0] exp_q [$];
    int          lat, sent, got;
    logic        hold;

    rst_n = 1'b0; rst_m = 1'b0;
    m_a = '0; m_b = '0; m_cin = 1'b0; m_sub = 1'b0; m_iv = 1'b0; m_or = 1'b0;
    e_a = '0; e_b = '0; e_cin = 1'b0; e_iv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(m_ov), 64'd0);
    check("rst_result", 64'({m_ovf, m_cout, m_y}), 64'd0);
    check("rst_in_ready", 64'(m_ir), 64'd1);
    @(negedge clk);
    rst_n = 1'b1; rst_m = 1'b1;

    // exhaustive 4-bit add, latency 1
    for (int v = 0; v < 512; v++) begin
      @(negedge clk);
      e_a = v[3:0]; e_b = v[7:4]; e_cin = v[8]; e_iv = 1'b1;
      if (v == 0) check("exh_ready", 64'(e_ir), 64'd1);
      @(posedge clk); #1;
      check("exh_valid", 64'(e_ov), 64'd1);
      check("exh_sum", 64'({e_co, e_y}), 64'(e_a) + 64'(e_b) + 64'(e_cin));
    end
    @(negedge clk); e_iv = 1'b0;
    @(posedge clk); #1;
    check("exh_bubble", 64'(e_ov), 64'd0);
    check("exh_ovf_defined", 64'(e_of ^ e_of), 64'd0);

    // directed 16-bit corners, latency 4
    run_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, r, lat);
    check("add_wrap", r, 64'h0_0000 | (64'd1 << 16));
    check("lat_wrap", 64'(lat), 64'd4);
    run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, r, lat);
    check("add_ovf", r, 64'h2_8000);
    check("lat_ovf", 64'(lat), 64'd4);
    run_one(16'h0003, 16'h0005, 1'b1, 1'b1, r, lat);
    check("sub_borrow", r, 64'h0_FFFE);
    run_one(16'h8000, 16'h0001, 1'b0, 1'b1, r, lat);
    check("sub_ovf", r, 64'h3_7FFF);
    m_or = 1'b1;
    repeat (3) @(posedge clk);

    // randomly stalled stream of 100 transfers
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 3000 && got < 100; cyc++) begin
      @(negedge clk);
      m_iv  = (sent < 100) && ($urandom_range(0, 1) == 1);
      m_a   = 16'($urandom); m_b = 16'($urandom);
      m_cin = 1'($urandom); m_sub = 1'($urandom);
      m_or  = ($urandom_range(0, 1) == 1);
      #1;
      if (m_iv && m_ir) begin
        exp_q.push_back(ref_add(16, 64'(m_a), 64'(m_b), m_cin, m_sub));
        sent++;
      end
      if (m_ov && m_or) begin
        if (exp_q.size() == 0) begin
          check("stream_extra", 64'd1, 64'd0);
        end else begin
          exp = exp_q.pop_front();
          check("stream_result", 64'({m_ovf, m_cout, m_y}), exp);
        end
        got++;
      end
      hold = m_ov && !m_or;
      prev = 64'({m_ovf, m_cout, m_y});
      @(posedge clk); #1;
      if (hold) begin
        check("stall_valid", 64'(m_ov), 64'd1);
        check("stall_hold", 64'({m_ovf, m_cout, m_y}), prev);
      end
    end
    check("stream_in_count", 64'(sent), 64'd100);
    check("stream_out_count", 64'(got), 64'd100);
    check("stream_queue_empty", 64'(exp_q.size()), 64'd0);

    // reset with three transactions in flight
    @(negedge clk); m_iv = 1'b0; m_or = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    m_a = 16'h1234; m_b = 16'h1111; m_cin = 1'b0; m_sub = 1'b0; m_iv = 1'b1;
    @(negedge clk); m_a = 16'h0F0F; m_b = 16'h00F0;
    @(negedge clk); m_a = 16'h4000; m_b = 16'h2000;
    @(negedge clk); m_iv = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_valid", 64'(m_ov), 64'd1);
    check("pre_rst_result", 64'({m_ovf, m_cout, m_y}), 64'h2345);
    #1 rst_m = 1'b0;
    #1;
    check("rst_async_valid", 64'(m_ov), 64'd0);
    check("rst_async_result", 64'({m_ovf, m_cout, m_y}), 64'd0);
    @(negedge clk); rst_m = 1'b1;
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); #1;
      check("post_rst_no_stale", 64'(m_ov), 64'd0);
    end
    run_one(16'h0102, 16'h0304, 1'b1, 1'b0, r, lat);
    check("post_rst_result", r, 64'h0407);
    check("post_rst_lat", 64'(lat), 64'd4);

    for (int t = 0; t < 5000 && !(sw[0].done && sw[1].done && sw[2].done && sw[3].done); t++)
      @(posedge clk);
    check("sweep_done", 64'(sw[0].done && sw[1].done && sw[2].done && sw[3].done), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
